pio_gpio_ctrl: RTL

- Parametrised, bus-addressed successor to the single-register LED output port.
- Provides a byte-writable output register driving active-low LEDs and a general output bus.
- Adds a synchronised input port with rising-edge capture, a maskable interrupt and a write-1-to-clear status register.
- Sits on the CPU peripheral bus beside the memory-mapped 7-seg/switch blocks; the CPU writes on the rising edge, and this block captures on the falling edge of clk.

---
 rtl/pio_gpio_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pio_gpio_ctrl.sv
// pio_gpio_ctrl: bus-addressed GPIO block. Byte-writable OUT register drives
// gpio_out and active-low LEDs. Inputs pass through a two-flop synchroniser
// with rising-edge capture into a W1C STATUS register, and irq = |(STATUS & MASK).
// Build option: define PIO_BLINK_EN to add the BLINK register (addr 4) and a
// free-running blink phase that is XORed into the LED outputs.
// All state updates on the falling edge of clk because the CPU drives the bus
// on the rising edge.
module pio_gpio_ctrl #(
  parameter int DATA_W    = 32,
  parameter int LED_W     = 8,
  parameter int IN_W      = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2:0]            addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  input  logic [IN_W-1:0]       gpio_in,
  output logic [DATA_W-1:0]     gpio_out,
  output logic [LED_W-1:0]      led,
  output logic                  irq
);

  localparam int NB = DATA_W / 8;

  // Expand byte enables into a per-bit write mask.
  logic [DATA_W-1:0] bmask;
  for (genvar i = 0; i < NB; i++) begin : g_be
    assign bmask[i*8 +: 8] = {8{be[i]}};
  end

  logic wr_out, wr_mask, wr_status;
  assign wr_out    = en && (addr == 3'd0);
  assign wr_mask   = en && (addr == 3'd2);
  assign wr_status = en && (addr == 3'd3);

  logic [DATA_W-1:0] out_q, out_d;
  logic [IN_W-1:0]   mask_q, mask_d, status_q, status_d;
  logic [IN_W-1:0]   s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [IN_W-1:0]   rise, clr;

  assign rise = s2_q & ~prev_q;

  // Next-state for registers and synchroniser; a set on the same edge as a clear wins.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    s1_d     = gpio_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    clr      = '0;
    if (wr_out)    out_d  = (out_q & ~bmask) | (wdata & bmask);
    if (wr_mask)   mask_d = (mask_q & ~bmask[IN_W-1:0]) | (wdata[IN_W-1:0] & bmask[IN_W-1:0]);
    if (wr_status) clr    = wdata[IN_W-1:0] & bmask[IN_W-1:0];
    status_d = (status_q & ~clr) | rise;
  end

  // Register state, falling-edge clocked with async active-low clear.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
    end else begin
      out_q    <= out_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
    end
  end

  assign gpio_out = out_q;
  assign irq      = |(status_q & mask_q);

`ifdef PIO_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [LED_W-1:0] blink_q, blink_d;
  logic             wr_blink;
  assign wr_blink = en && (addr == 3'd4);

  // Free-running divider; phase flips on wrap. BLINK writes leave the divider alone.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    blink_d = blink_q;
    if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (wr_blink)
      blink_d = (blink_q & ~bmask[LED_W-1:0]) | (wdata[LED_W-1:0] & bmask[LED_W-1:0]);
  end

  // Blink state registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign led = ~out_q[LED_W-1:0] ^ (blink_q & {LED_W{phase_q}});
`else
  logic unused_div;
  assign unused_div = (BLINK_DIV > 0);
  assign led = ~out_q[LED_W-1:0];
`endif

  // Combinational read mux; narrow registers zero-extend, unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata = out_q;
      3'd1: rdata[IN_W-1:0] = s2_q;
      3'd2: rdata[IN_W-1:0] = mask_q;
      3'd3: rdata[IN_W-1:0] = status_q;
`ifdef PIO_BLINK_EN
      3'd4: rdata[LED_W-1:0] = blink_q;
`endif
      default: rdata = '0;
    endcase
  end

endmodule
